// File: rtl/out_channel_fifo.sv
// out_channel_fifo: in-order output buffer between the executor's out channel and a valid/ready consumer.
// Ports:
//   clock, reset         rising-edge clock, synchronous active-high reset
//   write, writeData     executor push strobe and word
//   outValid, outReady   stream handshake toward the consumer
//   outData              head-of-FIFO word (meaningful only while outValid)
//   count, full, empty   occupancy status
//   overflow             sticky flag: a write was dropped since reset
//   words, dropped       accepted-word counter (wrapping) and dropped-word counter (saturating)
//   sum                  running checksum of accepted words when OUT_CHANNEL_FIFO_SUM_EN is defined, else 0
module out_channel_fifo #(
    parameter int MemoryElementWidth = 12,
    parameter int Depth              = 16,
    parameter int CountWidth         = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          write,
    input  logic [MemoryElementWidth-1:0] writeData,
    output logic                          outValid,
    input  logic                          outReady,
    output logic [MemoryElementWidth-1:0] outData,
    output logic [$clog2(Depth+1)-1:0]    count,
    output logic                          full,
    output logic                          empty,
    output logic                          overflow,
    output logic [CountWidth-1:0]         words,
    output logic [CountWidth-1:0]         dropped,
    output logic [MemoryElementWidth-1:0] sum
);
    localparam int AW = $clog2(Depth);
    localparam int NW = $clog2(Depth+1);
    logic [MemoryElementWidth-1:0] r_mem [Depth];
    logic [AW-1:0]                 r_rd, r_wr;
    logic [NW-1:0]                 r_count;
    logic                          r_overflow;
    logic [CountWidth-1:0]         r_words, r_dropped;
    logic                          w_pop, w_push, w_drop;
    assign empty    = r_count == '0;
    assign full     = r_count == NW'(Depth);
    assign outValid = !empty;
    assign outData  = r_mem[r_rd];
    assign count    = r_count;
    assign overflow = r_overflow;
    assign words    = r_words;
    assign dropped  = r_dropped;
    assign w_pop    = outValid && outReady;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign w_push   = write && (!full || w_pop);
    assign w_drop   = write && !w_push;
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rd       <= '0;
            r_wr       <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_words    <= '0;
            r_dropped  <= '0;
        end else begin
            if (w_pop) r_rd <= r_rd + AW'(1);
            if (w_push) begin
                r_wr    <= r_wr + AW'(1);
                r_words <= r_words + CountWidth'(1);
            end
            r_count <= r_count + NW'(w_push) - NW'(w_pop);
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (~&r_dropped) r_dropped <= r_dropped + CountWidth'(1);
            end
        end
    end
    // Storage is never cleared; reset only blocks the write that coincides with it.
    always_ff @(posedge clock) begin
        if (w_push && !reset) r_mem[r_wr] <= writeData;
    end
`ifdef OUT_CHANNEL_FIFO_SUM_EN
    logic [MemoryElementWidth-1:0] r_sum;
    always_ff @(posedge clock) begin
        if (reset) r_sum <= '0;
        else if (w_push) r_sum <= r_sum + writeData;
    end
    assign sum = r_sum;
`else
    assign sum = '0;
`endif
endmodule
